// File: rtl/axi_wr_sink_pkg.sv
// Shared types, constants and helpers for the AXI3 write-channel sink.
package axi_wr_sink_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Queue entries carry IDs at this width; the top's ID_W must not exceed it.
    localparam int ID_MAX_W = 16;

    typedef struct packed {
        logic [31:0]         addr;
        logic [ID_MAX_W-1:0] id;
        logic [3:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic                err;
    } aw_entry_t;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [1:0]          resp;
    } b_entry_t;

    function automatic logic [7:0] byte_parity(input logic [63:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

    function automatic logic [31:0] next_beat_addr(input logic [31:0] addr, input logic [3:0] len,
                                                   input logic [2:0] size, input logic [1:0] burst,
                                                   input logic [3:0] k);
        logic [31:0] step, lane, span, res;
        step = {28'd0, k} << size;
        lane = (32'd1 << size) - 32'd1;
        span = (({28'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_FIXED: res = addr;
            BURST_WRAP:  res = (addr & ~span) | ((addr + step) & span);
            BURST_INCR:  res = (k == 4'd0) ? addr : (addr & ~lane) + step;
            default:     res = addr;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/axi_wr_sink_fifo.sv
// Synchronous FIFO with registered occupancy; pushes when full and pops when empty are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/axi_wr_sink.sv
// AXI3 write-channel sink: checks address parity, data byte-parity and burst legality,
// commits each beat and returns one B response per burst.
module axi_wr_sink #(
    parameter int ID_W     = 9,
    parameter int AW_DEPTH = 4,
    parameter int B_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic [31:0]     awaddr,
    input  logic [3:0]      awaddr_parity,
    input  logic [1:0]      awburst,
    input  logic [ID_W-1:0] awid,
    input  logic [3:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic            awvalid,
    output logic            awready,
    input  logic [63:0]     wdata,
    input  logic [7:0]      wdata_ecc,
    input  logic [ID_W-1:0] wid,
    input  logic [7:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    output logic            wr_en,
    output logic [31:0]     wr_addr,
    output logic [63:0]     wr_data,
    output logic [7:0]      wr_strb,
    output logic [15:0]     err_cnt
);
    import axi_wr_sink_pkg::*;

    localparam int AW_CW = $clog2(AW_DEPTH) + 1;
    localparam int B_CW  = $clog2(B_DEPTH) + 1;
    localparam logic [AW_CW-1:0] AW_FULL = AW_DEPTH[AW_CW-1:0];

    aw_entry_t        aw_in, aw_head;
    b_entry_t         b_in, b_head;
    logic             aw_push, aw_pop, aw_full, aw_empty;
    logic [AW_CW-1:0] aw_count, aw_count_nxt;
    logic             b_push, b_pop, b_full, b_empty;
    logic [B_CW-1:0]  b_count;

    logic             awready_q, awready_d;
    logic [3:0]       k_q, k_d;
    logic             berr_q, berr_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             wr_en_q;
    logic [31:0]      wr_addr_q;
    logic [63:0]      wr_data_q;
    logic [7:0]       wr_strb_q;

    logic [7:0]       awpar, wpar;
    logic             w_fire, beat_err, last_by_len, burst_end, len_err;
    logic [1:0]       resp;
    logic             unused_bits;

    always_comb begin
        awpar        = byte_parity({32'd0, awaddr});
        aw_in        = '0;
        aw_in.addr   = awaddr;
        aw_in.id     = ID_MAX_W'(awid);
        aw_in.len    = awlen;
        aw_in.size   = awsize;
        aw_in.burst  = awburst;
        aw_in.err    = (awaddr_parity != awpar[3:0]) || (awburst == 2'b11) || (awsize > 3'd3)
                    || ((awburst == BURST_WRAP)
                        && (((awaddr & ((32'd1 << awsize) - 32'd1)) != 32'd0)
                            || !(awlen inside {4'd1, 4'd3, 4'd7, 4'd15})));
    end

    assign aw_push = awvalid && awready_q && !aw_full;

    sync_fifo #(.WIDTH($bits(aw_entry_t)), .DEPTH(AW_DEPTH)) u_aw_q (
        .clk(clk), .rstb(rstb), .push_i(aw_push), .pop_i(aw_pop), .data_i(aw_in),
        .data_o(aw_head), .full_o(aw_full), .empty_o(aw_empty), .count_o(aw_count)
    );

    assign wready = !aw_empty && !b_full;

    // A burst closes on whichever comes first: wlast or the beat count reaching len.
    always_comb begin
        wpar        = byte_parity(wdata);
        w_fire      = wvalid && wready;
        beat_err    = (ID_MAX_W'(wid) != aw_head.id) || (wdata_ecc != wpar);
        last_by_len = (k_q == aw_head.len);
        burst_end   = w_fire && (wlast || last_by_len);
        len_err     = (wlast != last_by_len);
        resp        = (aw_head.err || beat_err || berr_q || len_err) ? RESP_SLVERR : RESP_OKAY;

        k_d    = k_q;
        berr_d = berr_q;
        if (burst_end) begin
            k_d    = '0;
            berr_d = 1'b0;
        end else if (w_fire) begin
            k_d    = k_q + 4'd1;
            berr_d = berr_q || beat_err;
        end

        err_cnt_d = err_cnt_q;
        if (burst_end && (resp == RESP_SLVERR) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end

        aw_count_nxt = aw_count + AW_CW'(aw_push) - AW_CW'(aw_pop);
        awready_d    = (aw_count_nxt != AW_FULL);
    end

    assign aw_pop    = burst_end;
    assign b_push    = burst_end;
    assign b_in.id   = aw_head.id;
    assign b_in.resp = resp;

    sync_fifo #(.WIDTH($bits(b_entry_t)), .DEPTH(B_DEPTH)) u_b_q (
        .clk(clk), .rstb(rstb), .push_i(b_push), .pop_i(b_pop), .data_i(b_in),
        .data_o(b_head), .full_o(b_full), .empty_o(b_empty), .count_o(b_count)
    );

    assign bvalid = !b_empty;
    assign b_pop  = bvalid && bready;
    assign bid    = bvalid ? b_head.id[ID_W-1:0] : '0;
    assign bresp  = bvalid ? b_head.resp : RESP_OKAY;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            awready_q <= 1'b0;
            k_q       <= '0;
            berr_q    <= 1'b0;
            err_cnt_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
        end else begin
            awready_q <= awready_d;
            k_q       <= k_d;
            berr_q    <= berr_d;
            err_cnt_q <= err_cnt_d;
            wr_en_q   <= w_fire && !aw_head.err && !beat_err;
            if (w_fire) begin
                wr_addr_q <= next_beat_addr(aw_head.addr, aw_head.len, aw_head.size,
                                            aw_head.burst, k_q);
                wr_data_q <= wdata;
                wr_strb_q <= wstrb;
            end
        end
    end

    assign awready = awready_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_strb = wr_strb_q;
    assign err_cnt = err_cnt_q;

    assign unused_bits = ^{b_count, b_head.id, awpar[7:4]};

endmodule

// File: tb/tb_axi_wr_sink.sv
// Directed bench for axi_wr_sink: table of single bursts plus hand-written queueing/reset sequences.
module tb_axi_wr_sink;
    localparam int ID_W = 9;
    localparam int NV   = 11;

    logic            clk = 1'b0;
    logic            rstb;
    logic [31:0]     awaddr;
    logic [3:0]      awaddr_parity;
    logic [1:0]      awburst;
    logic [ID_W-1:0] awid;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic            awvalid, awready;
    logic [63:0]     wdata;
    logic [7:0]      wdata_ecc;
    logic [ID_W-1:0] wid;
    logic [7:0]      wstrb;
    logic            wlast, wvalid, wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid, bready;
    logic            wr_en;
    logic [31:0]     wr_addr;
    logic [63:0]     wr_data;
    logic [7:0]      wr_strb;
    logic [15:0]     err_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_wr_sink #(.ID_W(ID_W), .AW_DEPTH(4), .B_DEPTH(4)) dut (
        .clk(clk), .rstb(rstb),
        .awaddr(awaddr), .awaddr_parity(awaddr_parity), .awburst(awburst), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wdata_ecc(wdata_ecc), .wid(wid), .wstrb(wstrb),
        .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .err_cnt(err_cnt)
    );

    typedef struct {
        logic [31:0]      addr;
        logic [3:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [ID_W-1:0]  id;
        logic [3:0]       pflip;
        int               nbeats;
        int               wlast_beat;
        int               ecc_bad;
        int               wid_bad;
        logic [3:0]       exp_en;
        logic [3:0][31:0] exp_a;
        logic [1:0]       resp;
        logic [15:0]      err;
    } vec_t;

    vec_t vt[NV];

    function automatic logic [7:0] par8(input logic [63:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_aw(input logic [31:0] a, input logic [3:0] len, input logic [2:0] sz,
                          input logic [1:0] bt, input logic [ID_W-1:0] id, input logic [3:0] pflip);
        logic [7:0] p;
        p             = par8({32'd0, a});
        awaddr        = a;
        awlen         = len;
        awsize        = sz;
        awburst       = bt;
        awid          = id;
        awaddr_parity = p[3:0] ^ pflip;
        awvalid       = 1'b1;
    endtask

    task automatic wait_aw();
        int n = 0;
        while (!awready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            chk("aw_timeout", awready, 1);
            awvalid = 1'b0;
            return;
        end
        tick();
        awvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [3:0] len, input logic [2:0] sz,
                           input logic [1:0] bt, input logic [ID_W-1:0] id, input logic [3:0] pflip);
        set_aw(a, len, sz, bt, id, pflip);
        wait_aw();
    endtask

    task automatic send_beat(input logic [ID_W-1:0] id, input int b, input logic last,
                             input logic eflip, input logic exp_en, input logic [31:0] exp_addr);
        logic [63:0] wd;
        logic [7:0]  ws;
        int n = 0;
        wd        = {32'hC0DE_0000 + 32'(b), 32'h1357_9BD0 ^ 32'(b * 7)};
        ws        = 8'hFF >> b;
        wdata     = wd;
        wstrb     = ws;
        wid       = id;
        wlast     = last;
        wdata_ecc = par8(wd) ^ {7'd0, eflip};
        wvalid    = 1'b1;
        while (!wready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            chk("w_timeout", wready, 1);
            wvalid = 1'b0;
            return;
        end
        tick();
        wvalid = 1'b0;
        wlast  = 1'b0;
        chk($sformatf("wr_en beat%0d", b), wr_en, exp_en);
        if (exp_en) begin
            chk($sformatf("wr_addr beat%0d", b), wr_addr, exp_addr);
            chk($sformatf("wr_data beat%0d", b), wr_data, wd);
            chk($sformatf("wr_strb beat%0d", b), wr_strb, ws);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        send_aw(v.addr, v.len, v.size, v.burst, v.id, v.pflip);
        for (int b = 0; b < v.nbeats; b++) begin
            send_beat(v.id ^ ID_W'(b == v.wid_bad), b, b == v.wlast_beat, b == v.ecc_bad,
                      v.exp_en[b], v.exp_a[b]);
        end
        chk($sformatf("v%0d bvalid", idx), bvalid, 1);
        chk($sformatf("v%0d bid", idx), bid, v.id);
        chk($sformatf("v%0d bresp", idx), bresp, v.resp);
        chk($sformatf("v%0d err_cnt", idx), err_cnt, v.err);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk($sformatf("v%0d bvalid_after_pop", idx), bvalid, 0);
        chk($sformatf("v%0d wr_en_pulse", idx), wr_en, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " awready"}, awready, 0);
        chk({tag, " wready"},  wready, 0);
        chk({tag, " bvalid"},  bvalid, 0);
        chk({tag, " bid"},     bid, 0);
        chk({tag, " bresp"},   bresp, 0);
        chk({tag, " wr_en"},   wr_en, 0);
        chk({tag, " wr_addr"}, wr_addr, 0);
        chk({tag, " wr_data"}, wr_data, 0);
        chk({tag, " wr_strb"}, wr_strb, 0);
        chk({tag, " err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0;
        rstb = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; wlast = 1'b0;
        awaddr = '0; awaddr_parity = '0; awburst = '0; awid = '0; awlen = '0; awsize = '0;
        wdata = '0; wdata_ecc = '0; wid = '0; wstrb = '0;

        //         addr      len   size  burst  id     pflip  nb wl  ecc wid  en       exp_a (beat3..beat0)                            resp   err
        vt[0]  = '{32'h1000, 4'd3, 3'd3, 2'b01, 9'd5,  4'h0, 4, 3, -1, -1, 4'b1111, {32'h1018, 32'h1010, 32'h1008, 32'h1000}, 2'b00, 16'd0};
        vt[1]  = '{32'h1018, 4'd3, 3'd3, 2'b10, 9'd7,  4'h0, 4, 3, -1, -1, 4'b1111, {32'h1010, 32'h1008, 32'h1000, 32'h1018}, 2'b00, 16'd0};
        vt[2]  = '{32'h2000, 4'd3, 3'd3, 2'b01, 9'd6,  4'h4, 4, 3, -1, -1, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0},             2'b10, 16'd1};
        vt[3]  = '{32'h3004, 4'd1, 3'd2, 2'b00, 9'd1,  4'h0, 2, 1, -1, -1, 4'b0011, {32'h0, 32'h0, 32'h3004, 32'h3004},       2'b00, 16'd1};
        vt[4]  = '{32'h4003, 4'd2, 3'd2, 2'b01, 9'd2,  4'h0, 3, 2, -1, -1, 4'b0111, {32'h0, 32'h4008, 32'h4004, 32'h4003},    2'b00, 16'd1};
        vt[5]  = '{32'h5000, 4'd1, 3'd3, 2'b01, 9'd3,  4'h0, 2, -1, -1, -1, 4'b0011, {32'h0, 32'h0, 32'h5008, 32'h5000},      2'b10, 16'd2};
        vt[6]  = '{32'h6000, 4'd2, 3'd3, 2'b10, 9'd4,  4'h0, 3, 2, -1, -1, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0},             2'b10, 16'd3};
        vt[7]  = '{32'h7000, 4'd0, 3'd3, 2'b11, 9'd8,  4'h0, 1, 0, -1, -1, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0},             2'b10, 16'd4};
        vt[8]  = '{32'h7100, 4'd0, 3'd4, 2'b01, 9'd9,  4'h0, 1, 0, -1, -1, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0},             2'b10, 16'd5};
        vt[9]  = '{32'hC000, 4'd1, 3'd3, 2'b01, 9'd9,  4'h0, 2, 1, 1, -1,  4'b0001, {32'h0, 32'h0, 32'h0, 32'hC000},          2'b10, 16'd6};
        vt[10] = '{32'hD000, 4'd0, 3'd3, 2'b01, 9'hA,  4'h0, 1, 0, -1, 0,  4'b0000, {32'h0, 32'h0, 32'h0, 32'h0},             2'b10, 16'd7};

        tick();
        tick();
        chk_reset_outputs("reset");
        rstb = 1'b1;
        chk("awready_first_cycle", awready, 0);
        tick();
        chk("awready_after_reset", awready, 1);

        for (int i = 0; i < NV; i++) run_vec(vt[i], i);

        // Early wlast on a len=3 burst; the next queued AW must take the following beat.
        send_aw(32'h8000, 4'd3, 3'd3, 2'b01, 9'd3, 4'h0);
        send_aw(32'h9000, 4'd1, 3'd3, 2'b01, 9'd4, 4'h0);
        t0 = $time;
        send_beat(9'd3, 0, 1'b0, 1'b0, 1'b1, 32'h8000);
        send_beat(9'd3, 1, 1'b1, 1'b0, 1'b1, 32'h8008);
        chk("early bvalid", bvalid, 1);
        chk("early bid", bid, 3);
        chk("early bresp", bresp, 2'b10);
        send_beat(9'd4, 2, 1'b0, 1'b0, 1'b1, 32'h9000);
        send_beat(9'd4, 3, 1'b1, 1'b0, 1'b1, 32'h9008);
        chk("b2b_cycles", 64'(($time - t0) / 10), 4);
        chk("early bid_hold", bid, 3);
        chk("early err_cnt", err_cnt, 8);
        bready = 1'b1;
        tick();
        chk("next bid", bid, 4);
        chk("next bresp", bresp, 2'b00);
        tick();
        bready = 1'b0;
        chk("early drained", bvalid, 0);

        // Backpressure: AW queue fills at 4, then B queue fills at 4 with bready low.
        for (int i = 0; i < 4; i++) send_aw(32'hA000 + 32'(i * 8), 4'd0, 3'd3, 2'b01, ID_W'(10 + i), 4'h0);
        set_aw(32'hA020, 4'd0, 3'd3, 2'b01, 9'd14, 4'h0);
        tick();
        tick();
        chk("aw_full awready", awready, 0);
        chk("aw_full wready", wready, 1);
        send_beat(9'd10, 0, 1'b1, 1'b0, 1'b1, 32'hA000);
        wait_aw();
        for (int i = 1; i < 4; i++) send_beat(ID_W'(10 + i), i, 1'b1, 1'b0, 1'b1, 32'hA000 + 32'(i * 8));
        chk("b_full wready", wready, 0);
        chk("b_full awready", awready, 1);
        wid = 9'd14; wlast = 1'b1; wdata = '0; wdata_ecc = '0; wvalid = 1'b1;
        tick();
        tick();
        chk("b_full no_commit", wr_en, 0);
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d bvalid", i), bvalid, 1);
            chk($sformatf("drain%0d bid", i), bid, 10 + i);
            chk($sformatf("drain%0d bresp", i), bresp, 0);
            tick();
        end
        bready = 1'b0;
        chk("drained bvalid", bvalid, 0);
        chk("drained wready", wready, 1);
        send_beat(9'd14, 4, 1'b1, 1'b0, 1'b1, 32'hA020);
        chk("fifth bid", bid, 14);
        chk("fifth bresp", bresp, 0);
        chk("bp err_cnt", err_cnt, 8);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        // Reset after 2 of 4 beats: nothing of the burst survives.
        send_aw(32'hB000, 4'd3, 3'd3, 2'b01, 9'd2, 4'h0);
        send_beat(9'd2, 0, 1'b0, 1'b0, 1'b1, 32'hB000);
        send_beat(9'd2, 1, 1'b0, 1'b0, 1'b1, 32'hB008);
        rstb = 1'b0;
        tick();
        chk_reset_outputs("midreset");
        rstb = 1'b1;
        chk("midreset awready_first", awready, 0);
        tick();
        chk("midreset awready", awready, 1);
        chk("midreset no_b", bvalid, 0);
        run_vec(vt[0], 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
